exec_unit: RTL and testbench

- Execute stage sitting directly downstream of the register memory.
- Latches the two read operands (r_data1/r_data2) and a decoded op, computes the result, and drives the register memory write port (w_addr/w_data/write_en).
- Single-cycle ALU ops complete in one cycle. MUL/DIVU/REMU run iteratively over B cycles behind a busy/done handshake.

---
 rtl/exec_unit_pkg.sv | 27 ++
 rtl/exec_iter_muldiv.sv | 75 +++++++
 rtl/exec_unit.sv | 92 +++++++++
 tb/tb_exec_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute stage: op codes, FSM state encoding
// and the multi-cycle op classifier.
package exec_unit_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_WB   = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exec_iter_muldiv.sv
// Iterative MUL / DIVU / REMU datapath: shift-add multiply and restoring
// divide, one bit per step, B steps. Ports: load/op/opa/opb in, step
// advances one iteration, result/valid out (valid on the final step).
module exec_iter_muldiv
  import exec_unit_pkg::*;
#(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [3:0]   op,
  input  logic [B-1:0] opa,
  input  logic [B-1:0] opb,
  input  logic         step,
  output logic [B-1:0] result,
  output logic         valid
);

  localparam int CW = $clog2(B);

  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  // a: accumulator (MUL) or partial remainder (DIV)
  // d: shifting multiplicand (MUL) or divisor (DIV)
  // q: shifting multiplier (MUL) or dividend/quotient (DIV)
  logic [B-1:0]  a_q, d_q, q_q;
  logic [B-1:0]  a_n, d_n, q_n;
  logic [B:0]    rem_sh;
  logic          ge;

  always_comb begin
    a_n    = a_q;
    d_n    = d_q;
    q_n    = q_q;
    rem_sh = {a_q, q_q[B-1]};
    ge     = rem_sh >= {1'b0, d_q};
    if (op_q == OP_MUL) begin
      a_n = a_q + (q_q[0] ? d_q : '0);
      d_n = d_q << 1;
      q_n = q_q >> 1;
    end else begin
      // rem_sh < 2*divisor keeps the difference within B bits;
      // a zero divisor always "fits", giving all-ones / dividend.
      a_n = ge ? rem_sh[B-1:0] - d_q : rem_sh[B-1:0];
      q_n = {q_q[B-2:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      d_q  <= '0;
      q_q  <= '0;
    end else if (load) begin
      cnt  <= CW'(B - 1);
      op_q <= op;
      a_q  <= '0;
      d_q  <= (op == OP_MUL) ? opa : opb;
      q_q  <= (op == OP_MUL) ? opb : opa;
    end else if (step) begin
      a_q <= a_n;
      d_q <= d_n;
      q_q <= q_n;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  // Result reflects the step being taken this cycle.
  assign result = (op_q == OP_DIVU) ? q_n : a_n;
  assign valid  = step && (cnt == '0);

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIVU/REMU, driving
// the register-file write port. Ports: start/op/rs1_data/rs2_data/rd_addr
// in; busy/done and wb_en/wb_addr/wb_data out.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int B = 32,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [B-1:0] rs1_data,
  input  logic [B-1:0] rs2_data,
  input  logic [N-1:0] rd_addr,
  output logic         busy,
  output logic         done,
  output logic         wb_en,
  output logic [N-1:0] wb_addr,
  output logic [B-1:0] wb_data
);

  localparam int SW = $clog2(B);

  state_t        state, state_n;
  logic          accept;
  logic          multi;
  logic [B-1:0]  alu_y;
  logic [SW-1:0] shamt;
  logic [B-1:0]  it_result;
  logic          it_valid;

  assign accept = start && (state == S_IDLE);
  assign multi  = is_multicycle(op);
  assign shamt  = rs2_data[SW-1:0];

  always_comb begin
    alu_y = '0;
    unique case (op)
      OP_ADD:  alu_y = rs1_data + rs2_data;
      OP_SUB:  alu_y = rs1_data - rs2_data;
      OP_AND:  alu_y = rs1_data & rs2_data;
      OP_OR:   alu_y = rs1_data | rs2_data;
      OP_XOR:  alu_y = rs1_data ^ rs2_data;
      OP_SLT:  alu_y = B'($signed(rs1_data) < $signed(rs2_data));
      OP_SLL:  alu_y = rs1_data << shamt;
      OP_SRL:  alu_y = rs1_data >> shamt;
      default: alu_y = '0;
    endcase
  end

  exec_iter_muldiv #(.B(B)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept && multi),
    .op     (op),
    .opa    (rs1_data),
    .opb    (rs2_data),
    .step   (state == S_ITER),
    .result (it_result),
    .valid  (it_valid)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = multi ? S_ITER : S_WB;
      S_ITER:  if (it_valid) state_n = S_WB;
      S_WB:    state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      state <= state_n;
      if (accept) wb_addr <= rd_addr;
      if (accept && !multi) wb_data <= alu_y;
      else if ((state == S_ITER) && it_valid) wb_data <= it_result;
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_WB);
  assign wb_en = (state == S_WB) && (wb_addr != '0);

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed and random ops checked
// against an arithmetic reference model.
module tb_exec_unit;

  localparam int B = 32;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [B-1:0] rs1 = '0;
  logic [B-1:0] rs2 = '0;
  logic [N-1:0] rd = '0;
  logic         busy, done, wb_en;
  logic [N-1:0] wb_addr;
  logic [B-1:0] wb_data;

  exec_unit #(.B(B), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1_data (rs1),
    .rs2_data (rs2),
    .rd_addr  (rd),
    .busy     (busy),
    .done     (done),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [B-1:0] data;
    logic [N-1:0] addr;
    logic         wen;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_free = 0;
  int   busy_from = -10;
  int   busy_to = -10;
  bit   mon_en = 1'b0;

  function automatic logic [B-1:0] ref_res(logic [3:0] o,
                                           logic [B-1:0] a,
                                           logic [B-1:0] b);
    logic [B-1:0] r;
    case (o)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:    r = a << b[4:0];
      4'd7:    r = a >> b[4:0];
      4'd8:    r = a * b;
      4'd9:    r = (b == 0) ? '1 : a / b;
      4'd10:   r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void chk(string name, logic [B-1:0] act,
                              logic [B-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // Every posedge passes through here so cyc and the model stay in step.
  task automatic step(output bit acc);
    int lat;
    acc = 1'b0;
    @(posedge clk);
    cyc++;
    if (start && rst_n && cyc >= next_free) begin
      lat = (op >= 4'd8 && op <= 4'd10) ? B : 0;
      sb.push_back('{ref_res(op, rs1, rs2), rd, rd != 0, cyc + lat});
      busy_from = cyc;
      busy_to   = cyc + lat;
      next_free = cyc + lat + 2;
      acc = 1'b1;
    end
  endtask

  task automatic idle(int n);
    bit a;
    repeat (n) begin
      @(negedge clk);
      step(a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && cyc < next_free; i++) idle(1);
    idle(1);
  endtask

  task automatic issue(logic [3:0] o, logic [B-1:0] a,
                       logic [B-1:0] b, logic [N-1:0] r);
    bit acc = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
    for (int i = 0; i < 100 && !acc; i++) begin
      step(acc);
      if (!acc) @(negedge clk);
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept: op %0d not accepted", o);
    end
    @(negedge clk);
    start = 1'b0;
    step(acc);
  endtask

  function automatic logic [B-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return B'($urandom_range(0, 20));
      1:       return ($urandom_range(0, 1) != 0) ? '1 : 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", B'(busy), B'(cyc >= busy_from && cyc <= busy_to));
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missing_done: got none expected due %0d (cycle %0d)",
                 sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)",
                   cyc);
        end else begin
          e = sb.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_addr", B'(wb_addr), B'(e.addr));
          chk("wb_en", B'(wb_en), B'(e.wen));
        end
      end else begin
        chk("wb_en_idle", B'(wb_en), '0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit a;
    idle(3);
    chk("rst_busy", B'(busy), '0);
    chk("rst_done", B'(done), '0);
    chk("rst_wb_en", B'(wb_en), '0);
    chk("rst_wb_addr", B'(wb_addr), '0);
    chk("rst_wb_data", wb_data, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(a);
    @(negedge clk);
    #1 mon_en = 1'b1;
    step(a);

    issue(4'd0, 7, 5, 3);                 drain();
    issue(4'd1, 0, 1, 1);                 drain();
    issue(4'd5, 32'hFFFF_FFFF, 1, 2);     drain();
    issue(4'd6, 32'h0000_0003, 33, 5);    drain();
    issue(4'd7, 32'h8000_0000, 31, 6);    drain();
    issue(4'd8, 6, 7, 4);
    idle(10);
    // start pulse mid-iteration must be ignored
    @(negedge clk);
    start = 1'b1; op = 4'd0; rs1 = 1; rs2 = 1; rd = 9;
    step(a);
    @(negedge clk);
    start = 1'b0;
    step(a);
    drain();
    issue(4'd9, 100, 7, 7);               drain();
    issue(4'd10, 100, 7, 8);              drain();
    issue(4'd9, 5, 0, 10);                drain();
    issue(4'd10, 5, 0, 11);               drain();
    issue(4'd12, 9, 9, 12);               drain();
    issue(4'd0, 1, 2, 0);                 drain();

    // reset in the middle of a multiply
    issue(4'd8, 32'h1234, 32'h5678, 13);
    idle(10);
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", B'(busy), '0);
    chk("midrst_done", B'(done), '0);
    chk("midrst_wb_en", B'(wb_en), '0);
    sb.delete();
    busy_from = -10; busy_to = -10; next_free = 0;
    step(a);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(a);
    @(negedge clk);
    #1 mon_en = 1'b1;
    step(a);
    idle(40);
    issue(4'd0, 20, 22, 14);              drain();

    // start held high: back-to-back random ops
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = 1'b1;
      op  = 4'($urandom_range(0, 15));
      rs1 = pick();
      rs2 = pick();
      rd  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, 31));
      step(a);
    end
    @(negedge clk);
    start = 1'b0;
    step(a);
    drain();
    idle(2);
    chk("sb_empty", B'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
